// File: rtl/lfsr_parity_gen.sv
// Fibonacci LFSR word generator with parity, seed load, zero-seed lockup guard and a
// one-deep valid/ready output register. Define LFSR_PARITY_PERIOD_EN to enable the period counter.
module lfsr_parity_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             odd_par,
    input  logic             dout_ready,
    output logic [WIDTH:0]   dout,
    output logic             dout_valid,
    output logic             lockup,
    output logic             period_pulse,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] s, start, nxt, seed_eff;
    logic             fb, par, step, seed_zero;

    always_comb begin
        fb        = ^(s & TAPS);
        nxt       = {s[WIDTH-2:0], fb};
        par       = odd_par ? ~^nxt : ^nxt;
        step      = ena & ~load & (~dout_valid | dout_ready);
        seed_zero = (seed_in == '0);
        // a zero seed would freeze the register, so swap in the reset seed
        seed_eff  = seed_zero ? SEED : seed_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s          <= SEED;
            start      <= SEED;
            dout       <= {^SEED, SEED};
            dout_valid <= 1'b0;
            lockup     <= 1'b0;
        end else if (load) begin
            s          <= seed_eff;
            start      <= seed_eff;
            dout_valid <= 1'b0;
            lockup     <= seed_zero;
        end else if (step) begin
            s          <= nxt;
            dout       <= {par, nxt};
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef LFSR_PARITY_PERIOD_EN
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            period_len   <= '0;
            period_pulse <= 1'b0;
        end else begin
            period_pulse <= 1'b0;
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                if (nxt == start) begin
                    period_len   <= cnt + 1'b1;
                    period_pulse <= 1'b1;
                    cnt          <= '0;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
`else
    assign period_pulse = 1'b0;
    assign period_len   = '0;
`endif

endmodule

// File: tb/tb_lfsr_parity_gen.sv
// Randomized bench for lfsr_parity_gen (WIDTH=7, TAPS=7'h60) against a popcount-based
// behavioural model, plus literal checks of known sequence values.
module tb_lfsr_parity_gen;

    localparam int W = 7;
    localparam logic [W-1:0] TP = 7'h60;
    localparam logic [W-1:0] SD = 7'h01;

    logic         clk = 1'b0;
    logic         rst, ena, load, odd_par, dout_ready;
    logic [W-1:0] seed_in;
    logic [W:0]   dout;
    logic         dout_valid, lockup, period_pulse;
    logic [W-1:0] period_len;

    int vectors = 0;
    int errs    = 0;

    lfsr_parity_gen #(.WIDTH(W), .TAPS(TP), .SEED(SD)) dut (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .seed_in(seed_in),
        .odd_par(odd_par), .dout_ready(dout_ready), .dout(dout),
        .dout_valid(dout_valid), .lockup(lockup), .period_pulse(period_pulse),
        .period_len(period_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // next state: shift left, new LSB = odd number of ones under the tap mask
    function automatic logic [W-1:0] adv(input logic [W-1:0] v);
        return {v[W-2:0], 1'($countones(v & TP) % 2)};
    endfunction

    function automatic logic evenbit(input logic [W-1:0] v);
        return 1'($countones(v) % 2);
    endfunction

    // behavioural model
    logic [W-1:0] m_s, m_start, m_len, n, ns;
    logic [W:0]   m_dout;
    logic         m_valid, m_lock, m_pulse;
    int           m_cnt;
    bit           live = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s = SD; m_start = SD; m_dout = {evenbit(SD), SD};
            m_valid = 0; m_lock = 0; m_cnt = 0; m_len = '0; m_pulse = 0;
            live = 1;
        end else if (live) begin
            m_pulse = 0;
            if (load) begin
                ns = (seed_in == 0) ? SD : seed_in;
                m_s = ns; m_start = ns; m_valid = 0; m_lock = (seed_in == 0); m_cnt = 0;
            end else if (ena && (!m_valid || dout_ready)) begin
                n = adv(m_s);
                m_s = n;
                m_dout = {evenbit(n) ^ odd_par, n};
                m_valid = 1;
                if (n == m_start) begin
                    m_len = W'(m_cnt + 1); m_pulse = 1; m_cnt = 0;
                end else if (m_cnt < (1 << W) - 1) begin
                    m_cnt++;
                end
            end else if (m_valid && dout_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            vectors++;
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("dout", 32'(dout), 32'(m_dout));
            chk("lockup", 32'(lockup), 32'(m_lock));
            // odd parity mode: total ones in dout odd; even mode: even
            if (m_valid) chk("dout_ones_parity", 32'($countones(dout) % 2), 32'($countones(m_dout) % 2));
`ifdef LFSR_PARITY_PERIOD_EN
            chk("period_pulse", 32'(period_pulse), 32'(m_pulse));
            chk("period_len", 32'(period_len), 32'(m_len));
`else
            chk("period_pulse", 32'(period_pulse), 32'd0);
            chk("period_len", 32'(period_len), 32'd0);
`endif
        end
    end

    task automatic do_rst();
        rst = 1; ena = 0; load = 0; odd_par = 0; dout_ready = 0; seed_in = '0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic [W:0] seq [6];
        int hit;
        seq = '{8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41};

        do_rst();
        chk("reset_dout", 32'(dout), 32'h81);
        chk("reset_valid", 32'(dout_valid), 32'd0);

        // sustained stepping, one word per cycle
        ena = 1; dout_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("seq_word", 32'(dout), 32'(seq[i]));
            chk("seq_valid", 32'(dout_valid), 32'd1);
        end

        // backpressure holds the first word
        do_rst();
        ena = 1; dout_ready = 0;
        @(negedge clk);
        chk("bp_first", 32'(dout), 32'h82);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", 32'(dout), 32'h82);
            chk("bp_valid", 32'(dout_valid), 32'd1);
        end
        dout_ready = 1;
        @(negedge clk);
        chk("bp_release", 32'(dout), 32'h84);

        // odd parity
        do_rst();
        odd_par = 1; ena = 1; dout_ready = 1;
        @(negedge clk);
        chk("odd_first", 32'(dout), 32'h02);
        odd_par = 0; ena = 0;

        // zero seed load then valid seed load
        load = 1; seed_in = '0;
        @(negedge clk);
        chk("zload_lockup", 32'(lockup), 32'd1);
        chk("zload_valid", 32'(dout_valid), 32'd0);
        chk("zload_dout_hold", 32'(dout), 32'h02);
        load = 0; ena = 1;
        @(negedge clk);
        chk("zload_step", 32'(dout), 32'h82);
        ena = 0; load = 1; seed_in = 7'h15;
        @(negedge clk);
        chk("load_clr_lockup", 32'(lockup), 32'd0);
        load = 0; ena = 1;
        @(negedge clk);
        chk("load_step", 32'(dout), 32'hAA);

        // reset beats load
        rst = 1; load = 1; seed_in = 7'h55;
        @(negedge clk);
        chk("rstload_dout", 32'(dout), 32'h81);
        chk("rstload_valid", 32'(dout_valid), 32'd0);
        rst = 0; load = 0; ena = 1;
        @(negedge clk);
        chk("rstload_step", 32'(dout), 32'h82);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            load       = ($urandom_range(0, 15) == 0);
            seed_in    = ($urandom_range(0, 3) == 0) ? 7'h00 : W'($urandom);
            ena        = ($urandom_range(0, 3) != 0);
            dout_ready = $urandom_range(0, 1) == 1;
            odd_par    = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end

        // full period from a fresh seed
        rst = 0; load = 1; seed_in = 7'h01; ena = 0; odd_par = 0;
        @(negedge clk);
        load = 0; ena = 1; dout_ready = 1;
        hit = 0;
        for (int i = 1; i <= 200 && hit == 0; i++) begin
            @(negedge clk);
            if (period_pulse) hit = i;
        end
`ifdef LFSR_PARITY_PERIOD_EN
        chk("period_step", 32'(hit), 32'd127);
        chk("period_len_127", 32'(period_len), 32'd127);
`else
        chk("period_none", 32'(hit), 32'd0);
`endif
        ena = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
